project_switch_ctrl: RTL and testbench

//  Wishbone-slave controller that chooses which harness project owns the shared IO/clock/update resources.

---
 rtl/project_switch_ctrl_if.sv | 33 +++
 rtl/project_switch_ctrl.sv | 230 +++++++++++++++++++++++
 tb/tb_project_switch_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/project_switch_ctrl_if.sv
// project_switch_ctrl_if
// Wishbone slave bus bundle used between the bus master and project_switch_ctrl.
// The master modport drives the request side. The slave modport drives ack and read data.

interface project_switch_ctrl_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_stb_i,
        output wbs_cyc_i,
        output wbs_we_i,
        output wbs_adr_i,
        output wbs_dat_i,
        input  wbs_ack_o,
        input  wbs_dat_o
    );

    modport slave (
        input  wbs_stb_i,
        input  wbs_cyc_i,
        input  wbs_we_i,
        input  wbs_adr_i,
        input  wbs_dat_i,
        output wbs_ack_o,
        output wbs_dat_o
    );
endinterface

// File: rtl/project_switch_ctrl.sv
// project_switch_ctrl
// Wishbone-slave controller that picks which harness project owns the shared IO, clock and update resources.
// Every project change runs the same safe sequence:
//   - tristate the IOs and reset the old project (ASSERT)
//   - move the mux select (SWITCH)
//   - hold the new project in reset (HOLD)
//   - release the new project (RUN)
// Registers: CTRL at +0x00, DATA at +0x04, STATUS at +0x08. Any other address is not acknowledged.
// Optional build macro PSC_IDLE_GATE_EN: the outgoing project's clock is also gated during ASSERT,
// from the second ASSERT cycle onwards. Without the macro, that clock keeps running while its reset is applied.

module project_switch_ctrl #(
    parameter int unsigned  NUM_PROJECTS = 8,
    parameter logic [31:0]  BASE_ADDR    = 32'h3000_0000,
    parameter int unsigned  RST_CYCLES   = 4,
    localparam int unsigned SEL_W        = $clog2(NUM_PROJECTS)
) (
    input  logic                    wb_clk_i,
    input  logic                    reset_n,
    project_switch_ctrl_if.slave    wbs,
    output logic [SEL_W-1:0]        active_sel_o,
    output logic [NUM_PROJECTS-1:0] proj_clk_en_o,
    output logic [NUM_PROJECTS-1:0] proj_reset_o,
    output logic [NUM_PROJECTS-1:0] proj_wb_update_o,
    output logic                    io_oeb_force_o,
    output logic                    busy_o
);

    localparam logic [31:0] ADDR_CTRL   = BASE_ADDR;
    localparam logic [31:0] ADDR_DATA   = BASE_ADDR + 32'h4;
    localparam logic [31:0] ADDR_STATUS = BASE_ADDR + 32'h8;
    localparam logic [7:0]  CNT_INIT    = 8'(RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ASSERT = 2'd1,
        ST_SWITCH = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t                  state_q,     state_d;
    logic [7:0]              cnt_q,       cnt_d;
    logic [SEL_W-1:0]        activeSel_q, activeSel_d;
    logic [SEL_W-1:0]        pending_q,   pending_d;
    logic                    startReq_q,  startReq_d;
    logic                    forceReq_q,  forceReq_d;
    logic                    errSel_q,    errSel_d;
    logic                    errDrop_q,   errDrop_d;
    logic                    ack_q;
    logic [31:0]             rdData_q,    rdData_d;
    logic [NUM_PROJECTS-1:0] update_q,    update_d;

    logic                    addrCtrl;
    logic                    addrData;
    logic                    addrStatus;
    logic                    busHit;
    logic                    ctrlWr;
    logic                    dataWr;
    logic                    statusRd;
    logic [7:0]              reqRaw;
    logic                    reqForce;
    logic                    reqValid;
    logic [SEL_W-1:0]        reqSel;
    logic                    inRun;
    logic [NUM_PROJECTS-1:0] activeOneHot;
    logic [31:0]             statusWord;

    // A request is only accepted while ack is low, so every access gets exactly one single-cycle ack.
    assign addrCtrl   = (wbs.wbs_adr_i == ADDR_CTRL);
    assign addrData   = (wbs.wbs_adr_i == ADDR_DATA);
    assign addrStatus = (wbs.wbs_adr_i == ADDR_STATUS);
    assign busHit     = wbs.wbs_cyc_i && wbs.wbs_stb_i && !ack_q && (addrCtrl || addrData || addrStatus);
    assign ctrlWr     = busHit && wbs.wbs_we_i && addrCtrl;
    assign dataWr     = busHit && wbs.wbs_we_i && addrData;
    assign statusRd   = busHit && !wbs.wbs_we_i && addrStatus;

    // The full byte is range-checked, so a value such as 9 is rejected even when its low SEL_W bits are legal.
    assign reqRaw     = wbs.wbs_dat_i[7:0];
    assign reqForce   = wbs.wbs_dat_i[8];
    assign reqValid   = ({1'b0, reqRaw} < 9'(NUM_PROJECTS));
    assign reqSel     = reqRaw[SEL_W-1:0];

    assign inRun      = (state_q == ST_RUN);

    // Decode the active project index into a one-hot vector shared by clock enables, resets and update strobes.
    always_comb begin
        activeOneHot               = '0;
        activeOneHot[activeSel_q]  = 1'b1;
    end

    // Next-state logic for the switch sequencer, with CTRL writes folded in (a write overrides the FSM's clear).
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        activeSel_d = activeSel_q;
        pending_d   = pending_q;
        startReq_d  = startReq_q;
        forceReq_d  = forceReq_q;

        unique case (state_q)
            ST_RUN: begin
                if (startReq_q) begin
                    startReq_d = 1'b0;
                    forceReq_d = 1'b0;
                    if ((pending_q != activeSel_q) || forceReq_q) begin
                        state_d = ST_ASSERT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            ST_ASSERT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SWITCH: begin
                activeSel_d = pending_q;
                state_d     = ST_HOLD;
                cnt_d       = CNT_INIT;
            end
            ST_HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
        endcase

        // While a sequence is in flight, any valid request is parked. It is re-evaluated against the new active project on RUN entry.
        if (ctrlWr && reqValid) begin
            pending_d = reqSel;
            if (!inRun || (reqSel != activeSel_q) || reqForce) begin
                startReq_d = 1'b1;
                forceReq_d = reqForce;
            end
        end
    end

    // Sequencer state register; async reset lands in HOLD so project 0 comes up through a full reset hold.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_HOLD;
            cnt_q       <= CNT_INIT;
            activeSel_q <= '0;
            pending_q   <= '0;
            startReq_q  <= 1'b0;
            forceReq_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            activeSel_q <= activeSel_d;
            pending_q   <= pending_d;
            startReq_q  <= startReq_d;
            forceReq_q  <= forceReq_d;
        end
    end

    // STATUS layout: active select in the low bits, pending at [15:8], then busy, err_sel and err_drop.
    always_comb begin
        statusWord              = '0;
        statusWord[SEL_W-1:0]   = activeSel_q;
        statusWord[15:8]        = 8'(pending_q);
        statusWord[16]          = !inRun;
        statusWord[17]          = errSel_q;
        statusWord[18]          = errDrop_q;
    end

    // Bus side effects: error flags, read data and the project update strobe, all aligned with the ack cycle.
    always_comb begin
        errSel_d  = errSel_q;
        errDrop_d = errDrop_q;
        rdData_d  = '0;
        update_d  = '0;

        if (statusRd) begin
            rdData_d  = statusWord;
            errSel_d  = 1'b0;
            errDrop_d = 1'b0;
        end
        if (ctrlWr && !reqValid) begin
            errSel_d = 1'b1;
        end
        if (dataWr) begin
            if (inRun) begin
                update_d = activeOneHot;
            end else begin
                errDrop_d = 1'b1;
            end
        end
    end

    // Bus response registers; ack is a single-cycle pulse one cycle after the accepted request.
    always_ff @(posedge wb_clk_i or negedge reset_n) begin
        if (!reset_n) begin
            ack_q     <= 1'b0;
            rdData_q  <= '0;
            update_q  <= '0;
            errSel_q  <= 1'b0;
            errDrop_q <= 1'b0;
        end else begin
            ack_q     <= busHit;
            rdData_q  <= rdData_d;
            update_q  <= update_d;
            errSel_q  <= errSel_d;
            errDrop_q <= errDrop_d;
        end
    end

    // Harness-facing outputs derived from state; only the active project may leave reset, and only in RUN.
    always_comb begin
        proj_clk_en_o = activeOneHot;
`ifdef PSC_IDLE_GATE_EN
        if ((state_q == ST_ASSERT) && (cnt_q != CNT_INIT)) begin
            proj_clk_en_o = '0;
        end
`endif
        proj_reset_o   = inRun ? ~activeOneHot : '1;
        io_oeb_force_o = !inRun;
        busy_o         = !inRun;
    end

    assign active_sel_o     = activeSel_q;
    assign proj_wb_update_o = update_q;
    assign wbs.wbs_ack_o    = ack_q;
    assign wbs.wbs_dat_o    = rdData_q;

endmodule

// File: tb/tb_project_switch_ctrl.sv
// tb_project_switch_ctrl
// Self-checking bench for project_switch_ctrl with NUM_PROJECTS=8 and RST_CYCLES=4.
// Randomised targets and data are checked against a small model: active project, pending, and error flags.

module tb_project_switch_ctrl;
    localparam int          N        = 8;
    localparam int          R        = 4;
    localparam logic [31:0] BASE     = 32'h3000_0000;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_DATA   = BASE + 32'h4;
    localparam logic [31:0] A_STATUS = BASE + 32'h8;

    logic       clk = 1'b0;
    logic       resetN;
    logic [2:0] activeSel;
    logic [7:0] clkEn;
    logic [7:0] projReset;
    logic [7:0] projUpdate;
    logic       oebForce;
    logic       busy;

    int checkCount = 0;
    int errorCount = 0;

    int modelActive  = 0;
    int modelPending = 0;
    bit modelErrSel  = 1'b0;
    bit modelErrDrop = 1'b0;

    project_switch_ctrl_if bus();

    project_switch_ctrl #(
        .NUM_PROJECTS (N),
        .BASE_ADDR    (BASE),
        .RST_CYCLES   (R)
    ) dut (
        .wb_clk_i         (clk),
        .reset_n          (resetN),
        .wbs              (bus),
        .active_sel_o     (activeSel),
        .proj_clk_en_o    (clkEn),
        .proj_reset_o     (projReset),
        .proj_wb_update_o (projUpdate),
        .io_oeb_force_o   (oebForce),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] oneHot(input int idx);
        logic [7:0] v;
        v = 8'd1 << idx;
        return v;
    endfunction

    function automatic logic [31:0] expStatus(input bit busyNow);
        logic [31:0] w;
        w        = '0;
        w[2:0]   = 3'(modelActive);
        w[15:8]  = 8'(modelPending);
        w[16]    = busyNow;
        w[17]    = modelErrSel;
        w[18]    = modelErrDrop;
        return w;
    endfunction

    task automatic wbWrite(input logic [31:0] adr, input logic [31:0] dat, output bit acked);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b1;
        bus.wbs_adr_i = adr;
        bus.wbs_dat_i = dat;
        acked = 1'b0;
        for (int n = 0; n < 4 && !acked; n++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o === 1'b1) acked = 1'b1;
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        @(negedge clk);
    endtask

    task automatic wbRead(input logic [31:0] adr, output logic [31:0] dat, output bit acked);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = adr;
        acked = 1'b0;
        dat   = 'x;
        for (int n = 0; n < 4 && !acked; n++) begin
            @(posedge clk);
            #1;
            if (bus.wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                dat   = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (2) @(negedge clk);
        checkCount++; if (projReset !== 8'hFF) begin errorCount++; $display("[TB] FAIL rst_projReset: got %h expected %h", projReset, 8'hFF); end
        checkCount++; if (clkEn !== 8'h01) begin errorCount++; $display("[TB] FAIL rst_clkEn: got %h expected %h", clkEn, 8'h01); end
        checkCount++; if (activeSel !== 3'd0) begin errorCount++; $display("[TB] FAIL rst_active: got %0d expected 0", activeSel); end
        checkCount++; if (busy !== 1'b1 || oebForce !== 1'b1) begin errorCount++; $display("[TB] FAIL rst_busyOeb: got %b%b expected 11", busy, oebForce); end
        checkCount++; if (bus.wbs_ack_o !== 1'b0 || projUpdate !== 8'h00 || bus.wbs_dat_o !== 32'h0) begin errorCount++; $display("[TB] FAIL rst_bus: got ack=%b upd=%h dat=%h expected 0/00/0", bus.wbs_ack_o, projUpdate, bus.wbs_dat_o); end
        resetN = 1'b1;
        for (int k = 1; k <= R; k++) begin
            @(negedge clk);
            if (k < R) begin
                checkCount++; if (projReset !== 8'hFF) begin errorCount++; $display("[TB] FAIL rel_hold%0d: got %h expected %h", k, projReset, 8'hFF); end
            end
        end
        checkCount++; if (projReset !== 8'hFE) begin errorCount++; $display("[TB] FAIL rel_projReset: got %h expected %h", projReset, 8'hFE); end
        checkCount++; if (busy !== 1'b0 || oebForce !== 1'b0) begin errorCount++; $display("[TB] FAIL rel_busyOeb: got %b%b expected 00", busy, oebForce); end
        modelActive  = 0;
        modelPending = 0;
        modelErrSel  = 1'b0;
        modelErrDrop = 1'b0;
    endtask

    task automatic test_switch(input int target, input bit forceIt);
        bit         acked;
        logic [7:0] oldHot;
        logic [7:0] newHot;
        int         oldActive;
        oldActive = modelActive;
        oldHot    = oneHot(modelActive);
        newHot    = oneHot(target);
        wbWrite(A_CTRL, 32'(target) | (forceIt ? 32'h100 : 32'h0), acked);
        checkCount++; if (!acked || bus.wbs_ack_o !== 1'b1) begin errorCount++; $display("[TB] FAIL sw_ack: got %b expected 1", acked); end
        for (int k = 1; k <= 2 * R + 2; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checkCount++; if (bus.wbs_ack_o !== 1'b0) begin errorCount++; $display("[TB] FAIL sw_ackPulse: got %b expected 0", bus.wbs_ack_o); end
                checkCount++; if (projReset !== 8'hFF || oebForce !== 1'b1) begin errorCount++; $display("[TB] FAIL sw_assert: got %h/%b expected FF/1", projReset, oebForce); end
                checkCount++; if (clkEn !== oldHot) begin errorCount++; $display("[TB] FAIL sw_clkOld: got %h expected %h", clkEn, oldHot); end
            end
`ifdef PSC_IDLE_GATE_EN
            if (k == 2) begin
                checkCount++; if (clkEn !== 8'h00) begin errorCount++; $display("[TB] FAIL sw_clkGate: got %h expected 00", clkEn); end
            end
`else
            if (k == 2) begin
                checkCount++; if (clkEn !== oldHot) begin errorCount++; $display("[TB] FAIL sw_clkRun: got %h expected %h", clkEn, oldHot); end
            end
`endif
            if (k == R + 1) begin
                checkCount++; if (activeSel !== 3'(oldActive)) begin errorCount++; $display("[TB] FAIL sw_preSel: got %0d expected %0d", activeSel, oldActive); end
            end
            if (k == R + 2) begin
                checkCount++; if (activeSel !== 3'(target) || clkEn !== newHot) begin errorCount++; $display("[TB] FAIL sw_postSel: got %0d/%h expected %0d/%h", activeSel, clkEn, target, newHot); end
            end
            if (k == 2 * R + 1) begin
                checkCount++; if (projReset !== 8'hFF || busy !== 1'b1) begin errorCount++; $display("[TB] FAIL sw_holdEnd: got %h/%b expected FF/1", projReset, busy); end
            end
        end
        checkCount++; if (projReset !== ~newHot) begin errorCount++; $display("[TB] FAIL sw_release: got %h expected %h", projReset, ~newHot); end
        checkCount++; if (clkEn !== newHot || busy !== 1'b0 || oebForce !== 1'b0) begin errorCount++; $display("[TB] FAIL sw_run: got %h/%b/%b expected %h/0/0", clkEn, busy, oebForce, newHot); end
        modelActive  = target;
        modelPending = target;
    endtask

    task automatic test_data_update();
        bit          acked;
        bit          sawUpdate;
        int          t;
        logic [31:0] rd;
        wbWrite(A_DATA, $urandom, acked);
        checkCount++; if (!acked || projUpdate !== oneHot(modelActive)) begin errorCount++; $display("[TB] FAIL upd_strobe: got %b/%h expected 1/%h", acked, projUpdate, oneHot(modelActive)); end
        @(negedge clk);
        checkCount++; if (projUpdate !== 8'h00) begin errorCount++; $display("[TB] FAIL upd_oneCycle: got %h expected 00", projUpdate); end
        do t = $urandom_range(0, N - 1); while (t == modelActive);
        wbWrite(A_CTRL, 32'(t), acked);
        modelPending = t;
        wbWrite(A_DATA, $urandom, acked);
        sawUpdate = |projUpdate;
        checkCount++; if (!acked || sawUpdate) begin errorCount++; $display("[TB] FAIL upd_dropAck: got %b/%h expected 1/00", acked, projUpdate); end
        modelErrDrop = 1'b1;
        for (int n = 0; n < 40 && busy !== 1'b0; n++) begin
            @(negedge clk);
            sawUpdate = sawUpdate | (|projUpdate);
        end
        checkCount++; if (busy !== 1'b0 || sawUpdate) begin errorCount++; $display("[TB] FAIL upd_dropDone: got busy=%b upd=%b expected 0/0", busy, sawUpdate); end
        modelActive = t;
        wbRead(A_STATUS, rd, acked);
        checkCount++; if (!acked || rd !== expStatus(1'b0)) begin errorCount++; $display("[TB] FAIL upd_status: got %h expected %h", rd, expStatus(1'b0)); end
        modelErrDrop = 1'b0;
        modelErrSel  = 1'b0;
    endtask

    task automatic test_bad_sel();
        bit          acked;
        bit          sawBusy;
        logic [31:0] rd;
        logic [31:0] v;
        v = 32'($urandom_range(N, 255)) | ($urandom_range(0, 1) != 0 ? 32'h100 : 32'h0);
        wbWrite(A_CTRL, v, acked);
        sawBusy = 1'b0;
        for (int k = 1; k <= 2 * R + 4; k++) begin
            @(negedge clk);
            sawBusy = sawBusy | busy;
        end
        checkCount++; if (!acked || sawBusy || activeSel !== 3'(modelActive)) begin errorCount++; $display("[TB] FAIL bad_noSwitch: got ack=%b busy=%b sel=%0d expected 1/0/%0d", acked, sawBusy, activeSel, modelActive); end
        modelErrSel = 1'b1;
        wbRead(A_STATUS, rd, acked);
        checkCount++; if (!acked || rd !== expStatus(1'b0)) begin errorCount++; $display("[TB] FAIL bad_status1: got %h expected %h", rd, expStatus(1'b0)); end
        modelErrSel = 1'b0;
        wbRead(A_STATUS, rd, acked);
        checkCount++; if (!acked || rd !== expStatus(1'b0)) begin errorCount++; $display("[TB] FAIL bad_status2: got %h expected %h", rd, expStatus(1'b0)); end
    endtask

    task automatic test_last_wins();
        bit acked1;
        bit acked2;
        bit sawBusy;
        int a;
        int b;
        int c;
        a = modelActive;
        do b = $urandom_range(0, N - 1); while (b == a);
        do c = $urandom_range(0, N - 1); while (c == a || c == b);
        wbWrite(A_CTRL, 32'(b), acked1);
        wbWrite(A_CTRL, 32'(c), acked2);
        for (int k = 1; k <= 2 * R; k++) begin
            @(negedge clk);
            if (k == 2 * R - 1) begin
                checkCount++; if (projReset !== 8'hFF) begin errorCount++; $display("[TB] FAIL lw_hold: got %h expected FF", projReset); end
            end
        end
        checkCount++; if (!acked1 || !acked2 || activeSel !== 3'(c) || projReset !== ~oneHot(c)) begin errorCount++; $display("[TB] FAIL lw_final: got sel=%0d rst=%h expected %0d/%h", activeSel, projReset, c, ~oneHot(c)); end
        modelActive  = c;
        modelPending = c;
        sawBusy = 1'b0;
        for (int k = 1; k <= 2 * R + 4; k++) begin
            @(negedge clk);
            sawBusy = sawBusy | busy;
        end
        checkCount++; if (sawBusy) begin errorCount++; $display("[TB] FAIL lw_noRestart: got busy=%b expected 0", sawBusy); end
        wbWrite(A_CTRL, 32'(c), acked1);
        sawBusy = 1'b0;
        for (int k = 1; k <= 2 * R + 4; k++) begin
            @(negedge clk);
            sawBusy = sawBusy | busy;
        end
        checkCount++; if (!acked1 || sawBusy || projReset !== ~oneHot(c)) begin errorCount++; $display("[TB] FAIL lw_sameNoForce: got busy=%b rst=%h expected 0/%h", sawBusy, projReset, ~oneHot(c)); end
    endtask

    task automatic test_reset_midrun();
        bit          acked;
        int          t;
        logic [31:0] rd;
        logic [31:0] badAdr;
        do t = $urandom_range(1, N - 1); while (t == modelActive);
        wbWrite(A_CTRL, 32'(t), acked);
        for (int k = 1; k <= R + 3; k++) @(negedge clk);
        checkCount++; if (busy !== 1'b1 || activeSel !== 3'(t)) begin errorCount++; $display("[TB] FAIL mid_inHold: got busy=%b sel=%0d expected 1/%0d", busy, activeSel, t); end
        #2 resetN = 1'b0;
        #1;
        checkCount++; if (activeSel !== 3'd0 || projReset !== 8'hFF || clkEn !== 8'h01) begin errorCount++; $display("[TB] FAIL mid_async: got sel=%0d rst=%h clk=%h expected 0/FF/01", activeSel, projReset, clkEn); end
        checkCount++; if (busy !== 1'b1 || oebForce !== 1'b1 || projUpdate !== 8'h00) begin errorCount++; $display("[TB] FAIL mid_flags: got %b%b/%h expected 11/00", busy, oebForce, projUpdate); end
        @(negedge clk);
        resetN = 1'b1;
        modelActive  = 0;
        modelPending = 0;
        modelErrSel  = 1'b0;
        modelErrDrop = 1'b0;
        for (int n = 0; n < R + 6 && busy !== 1'b0; n++) @(negedge clk);
        checkCount++; if (busy !== 1'b0 || projReset !== 8'hFE) begin errorCount++; $display("[TB] FAIL mid_recover: got busy=%b rst=%h expected 0/FE", busy, projReset); end
        for (int i = 0; i < 3; i++) begin
            if (i == 0) badAdr = BASE + 32'h0C;
            else if (i == 1) badAdr = BASE + 32'h1;
            else badAdr = BASE + 32'h10 + (32'($urandom_range(0, 255)) << 2);
            wbWrite(badAdr, 32'($urandom_range(1, N - 1)), acked);
            checkCount++; if (acked) begin errorCount++; $display("[TB] FAIL unmapped_wr%0d: got ack=1 expected 0 at %h", i, badAdr); end
        end
        wbRead(BASE + 32'h14, rd, acked);
        checkCount++; if (acked) begin errorCount++; $display("[TB] FAIL unmapped_rd: got ack=1 expected 0"); end
        wbRead(A_STATUS, rd, acked);
        checkCount++; if (!acked || rd !== expStatus(1'b0) || busy !== 1'b0) begin errorCount++; $display("[TB] FAIL mid_status: got %h expected %h", rd, expStatus(1'b0)); end
    endtask

    initial begin
        int t;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_adr_i = '0;
        bus.wbs_dat_i = '0;
        resetN        = 1'b0;
        $display("[TB] starting project_switch_ctrl bench");
        test_reset();
        test_switch(3, 1'b0);
        for (int i = 0; i < 2; i++) begin
            do t = $urandom_range(0, N - 1); while (t == modelActive);
            test_switch(t, 1'b0);
        end
        test_data_update();
        test_bad_sel();
        test_last_wins();
        test_switch(modelActive, 1'b1);
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
